// File: rtl/seq_adder_pkg.sv
// -----------------------------------------------------------------------------
// seq_adder_pkg
// Shared definitions for the nibble-serial adder controller.
//   state_t      : controller FSM encoding (IDLE, RUN, DONE)
//   NIB_W        : width of one adder slice (4 bits)
//   MAX_NIBBLES  : largest supported operand length in slices
//   IDX_W        : width of the nibble index, sized for MAX_NIBBLES
// -----------------------------------------------------------------------------
package seq_adder_pkg;

    localparam int NIB_W       = 4;
    localparam int MAX_NIBBLES = 8;
    localparam int IDX_W       = $clog2(MAX_NIBBLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla4_slice.sv
// -----------------------------------------------------------------------------
// cla4_slice
// 4-bit carry-lookahead adder slice, purely combinational.
// Ports:
//   A, B  in  [NIB_W-1:0]  addends
//   cin   in  1            carry in
//   Y     out [NIB_W-1:0]  sum
//   cout  out 1            carry out
// -----------------------------------------------------------------------------
module cla4_slice
    import seq_adder_pkg::*;
(
    input  logic [NIB_W-1:0] A,
    input  logic [NIB_W-1:0] B,
    input  logic             cin,
    output logic [NIB_W-1:0] Y,
    output logic             cout
);

    logic [NIB_W-1:0] g;
    logic [NIB_W-1:0] p;
    logic [NIB_W-1:0] c;

    assign g = A & B;
    assign p = A ^ B;

    // Every carry is expanded directly from cin so no carry depends on another
    // carry signal (keeps the lookahead flat).
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign Y = p ^ c;

endmodule

// File: rtl/seq_adder_ctrl.sv
// -----------------------------------------------------------------------------
// seq_adder_ctrl
// Nibble-serial adder: one cla4_slice is reused for NIBBLES cycles to form
// {cout,Y} = A + B + cin.
// Optional feature macro: SEQ_ADDER_SUB_EN adds the 'sub' port; sub=1 at
// acceptance computes A - B (B inverted, carry-in forced to 1).
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   request handshake (A, B, cin, [sub])
//   out_valid / out_ready result handshake (Y, cout)
//   busy                  high whenever the FSM is not IDLE
//   state_dbg             current FSM state, for observation only
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. in_ready depends only on state, never on in_valid. Once out_valid is
// raised, Y and cout stay stable until the transfer completes.
// -----------------------------------------------------------------------------
module seq_adder_ctrl
    import seq_adder_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int W       = NIB_W * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         cin,
`ifdef SEQ_ADDER_SUB_EN
    input  logic         sub,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] Y,
    output logic         cout,
    output logic         busy,
    output state_t       state_dbg
);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     y_q;
    logic             cout_q;

    logic             accept;
    logic             last_nib;
    logic [W-1:0]     b_eff;
    logic             c_eff;
    logic [NIB_W-1:0] a_nib;
    logic [NIB_W-1:0] b_nib;
    logic [NIB_W-1:0] sum_nib;
    logic             sum_co;

    assign accept   = in_valid && in_ready;
    assign last_nib = (idx == IDX_W'(NIBBLES - 1));

    // Subtraction is A + ~B + 1; the inverted operand and forced carry are
    // captured once so the serial datapath itself only ever adds.
`ifdef SEQ_ADDER_SUB_EN
    assign b_eff = sub ? ~B : B;
    assign c_eff = sub ? 1'b1 : cin;
`else
    assign b_eff = B;
    assign c_eff = cin;
`endif

    // Select nibble 'idx' of the captured operands.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IDX_W'(i)) begin
                a_nib = a_q[i*NIB_W +: NIB_W];
                b_nib = b_q[i*NIB_W +: NIB_W];
            end
        end
    end

    cla4_slice u_slice (
        .A    (a_nib),
        .B    (b_nib),
        .cin  (carry),
        .Y    (sum_nib),
        .cout (sum_co)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)    state_nxt = RUN;
            RUN:     if (last_nib)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx    <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            y_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        a_q   <= A;
                        b_q   <= b_eff;
                        carry <= c_eff;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (idx == IDX_W'(i)) begin
                            y_q[i*NIB_W +: NIB_W] <= sum_nib;
                        end
                    end
                    carry <= sum_co;
                    if (last_nib) begin
                        cout_q <= sum_co;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    // DONE: result held until the consumer takes it
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign Y         = y_q;
    assign cout      = cout_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_seq_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_adder_ctrl
// Self-checking bench for seq_adder_ctrl (NIBBLES=4). Expected results are
// pushed to exp_q when a request is accepted and popped when the result is
// consumed.
// -----------------------------------------------------------------------------
module tb_seq_adder_ctrl;
    import seq_adder_pkg::*;

    localparam int NIBBLES = 4;
    localparam int W       = NIB_W * NIBBLES;

    // ---------------- clock / reset ----------------
    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic [W-1:0] A         = '0;
    logic [W-1:0] B         = '0;
    logic         cin       = 1'b0;
`ifdef SEQ_ADDER_SUB_EN
    logic         sub       = 1'b0;
`endif
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] Y;
    logic         cout;
    logic         busy;
    state_t       state_dbg;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    seq_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .cin       (cin),
`ifdef SEQ_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (Y),
        .cout      (cout),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard ----------------
    logic [W:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         accept_cyc = 0;

    // ---------------- driver tasks ----------------
    // Present a request at a negedge once in_ready is high; returns at the
    // negedge just after the accepting edge with operands scrambled.
    task automatic drive_req(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic c, input logic s);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
        end else begin
            in_valid = 1'b1;
            A        = a;
            B        = b;
            cin      = c;
`ifdef SEQ_ADDER_SUB_EN
            sub      = s;
`endif
            if (s)
                exp_q.push_back({1'b0, a} + {1'b0, ~b} + (W+1)'(1));
            else
                exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, c});
            @(negedge clk);
            accept_cyc = cyc;
            in_valid   = 1'b0;
            A          = W'($urandom);
            B          = W'($urandom);
            cin        = 1'($urandom_range(0, 1));
`ifdef SEQ_ADDER_SUB_EN
            sub        = 1'($urandom_range(0, 1));
`endif
        end
    endtask

    // Wait for out_valid; lat counts the acceptance cycle as cycle 1.
    task automatic wait_out(output logic [W:0] res, output int lat, output bit ok);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        ok  = (out_valid === 1'b1);
        res = {cout, Y};
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (Y !== '0)           begin errors++; $display("FAIL reset_y: got %h want 0", Y); end
        checks++; if (cout !== 1'b0)      begin errors++; $display("FAIL reset_cout: got %b want 0", cout); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", state_dbg, IDLE); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        logic [W-1:0] ta[4] = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h8000};
        logic [W-1:0] tb[4] = '{16'h4321, 16'h0000, 16'hFFFF, 16'h8000};
        logic         tc[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [W:0]   res;
        logic [W:0]   exp;
        int           lat;
        bit           ok;
        for (int i = 0; i < 12; i++) begin
            if (i < 4) drive_req(ta[i], tb[i], tc[i], 1'b0);
            else       drive_req(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            wait_out(res, lat, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL add_timeout[%0d]: out_valid=%b required 1", i, out_valid); end
            checks++;
            if (lat != NIBBLES + 1) begin errors++; $display("FAIL add_latency[%0d]: got %0d want %0d", i, lat, NIBBLES + 1); end
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL add_result[%0d]: got %h, no expected entry", i, res);
            end else begin
                exp = exp_q.pop_front();
                if (res !== exp) begin errors++; $display("FAIL add_result[%0d]: got %h want %h", i, res, exp); end
            end
            consume();
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL add_ready_return[%0d]: got %b want 1", i, in_ready); end
        end
    endtask

    task automatic test_backpressure();
        logic [W:0] res;
        logic [W:0] exp;
        int         lat;
        bit         ok;
        drive_req(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
        wait_out(res, lat, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_timeout: out_valid=%b required 1", out_valid); end
        exp = (exp_q.size() != 0) ? exp_q[0] : '0;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                in_valid = 1'b1;
                A        = 16'hAAAA;
                B        = 16'h5555;
            end
            @(negedge clk);
            in_valid = 1'b0;
            checks++; if ({cout, Y} !== exp) begin errors++; $display("FAIL bp_hold[%0d]: got %h want %h", k, {cout, Y}, exp); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", k, out_valid); end
            checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0", k, in_ready); end
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL bp_result: no expected entry");
        end else begin
            exp = exp_q.pop_front();
            if ({cout, Y} !== exp) begin errors++; $display("FAIL bp_result: got %h want %h", {cout, Y}, exp); end
        end
        consume();
        // The request pulsed during DONE must not have been queued.
        repeat (NIBBLES + 3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_dropped_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL bp_dropped_busy: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [W:0] res;
        logic [W:0] exp;
        int         lat;
        bit         ok;
        int         prev_acc;
        for (int i = 0; i < 3; i++) begin
            drive_req(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            if (i > 0) begin
                checks++;
                if (accept_cyc - prev_acc != NIBBLES + 2) begin
                    errors++; $display("FAIL b2b_period[%0d]: got %0d want %0d", i, accept_cyc - prev_acc, NIBBLES + 2);
                end
            end
            prev_acc = accept_cyc;
            wait_out(res, lat, ok);
            checks++;
            if (!ok || exp_q.size() == 0) begin
                errors++; $display("FAIL b2b_result[%0d]: no result (valid=%b)", i, out_valid);
            end else begin
                exp = exp_q.pop_front();
                if (res !== exp) begin errors++; $display("FAIL b2b_result[%0d]: got %h want %h", i, res, exp); end
            end
            consume();
        end
    endtask

`ifdef SEQ_ADDER_SUB_EN
    task automatic test_sub();
        logic [W-1:0] ta[3] = '{16'h0005, 16'h0007, 16'h1234};
        logic [W-1:0] tb[3] = '{16'h0007, 16'h0005, 16'h1234};
        logic [W:0]   tk[3] = '{17'h0FFFE, 17'h10002, 17'h10000};
        logic [W:0]   res;
        logic [W:0]   exp;
        int           lat;
        bit           ok;
        for (int i = 0; i < 3; i++) begin
            drive_req(ta[i], tb[i], 1'(i == 0), 1'b1);
            wait_out(res, lat, ok);
            checks++;
            if (!ok || exp_q.size() == 0) begin
                errors++; $display("FAIL sub_result[%0d]: no result (valid=%b)", i, out_valid);
            end else begin
                exp = exp_q.pop_front();
                if (res !== exp) begin errors++; $display("FAIL sub_result[%0d]: got %h want %h", i, res, exp); end
            end
            checks++;
            if (res !== tk[i]) begin errors++; $display("FAIL sub_known[%0d]: got %h want %h", i, res, tk[i]); end
            consume();
        end
    endtask
`endif

    task automatic test_abort();
        logic [W:0] res;
        logic [W:0] exp;
        int         lat;
        bit         ok;
        drive_req(16'h0F0F, 16'h1111, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (state_dbg !== RUN) begin errors++; $display("FAIL abort_in_run: got %0d want %0d", state_dbg, RUN); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b want 0", out_valid); end
        checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL abort_state: got %0d want %0d", state_dbg, IDLE); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        if (exp_q.size() != 0) void'(exp_q.pop_back());
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", in_ready); end
        drive_req(16'h0001, 16'h0001, 1'b0, 1'b0);
        wait_out(res, lat, ok);
        checks++;
        if (!ok || exp_q.size() == 0) begin
            errors++; $display("FAIL abort_new_result: no result (valid=%b)", out_valid);
        end else begin
            exp = exp_q.pop_front();
            if (res !== exp) begin errors++; $display("FAIL abort_new_result: got %h want %h", res, exp); end
        end
        checks++;
        if (res !== 17'h00002) begin errors++; $display("FAIL abort_new_known: got %h want 00002", res); end
        consume();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_add();
        test_backpressure();
        test_back_to_back();
`ifdef SEQ_ADDER_SUB_EN
        test_sub();
`endif
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_adder_ctrl.md
SEQ_ADDER_CTRL -- requirements
Module: seq_adder_ctrl

Interface
REQ-001 Parameter: NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 1..8.
REQ-002 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  in  1  reset, synchronous, active-low.
REQ-004 Port: in_valid  in  1  request carries valid operands.
REQ-005 Port: in_ready  out  1  controller can accept a request.
REQ-006 Port: A  in  W  first operand.
REQ-007 Port: B  in  W  second operand.
REQ-008 Port: cin  in  1  carry into nibble 0.
REQ-009 Port: sub  in  1  subtract request (present only with SEQ_ADDER_SUB_EN).
REQ-010 Port: out_valid  out  1  result available.
REQ-011 Port: out_ready  in  1  consumer accepts result.
REQ-012 Port: Y  out  W  result word.
REQ-013 Port: cout  out  1  carry out of the top nibble.
REQ-014 Port: busy  out  1  high whenever state is not IDLE.

Function
REQ-015 FSM states IDLE, RUN, DONE; one 4-bit adder instance is shared across all nibbles.
REQ-016 in_ready SHALL equal (state==IDLE); in_ready is not combinationally dependent on in_valid.
REQ-017 IDLE->RUN on in_valid&&in_ready; A, B, and the effective carry-in are captured, and the nibble index is cleared to 0.
REQ-018 In RUN, cycle k adds nibble k of the captured operands with the carry register; nibble k of Y is written and the carry register takes the adder's carry-out.
REQ-019 Carry into nibble 0 SHALL be the captured cin; carry into nibble k>0 SHALL be the adder carry-out from nibble k-1.
REQ-020 RUN->DONE after nibble NIBBLES-1; out_valid rises on the following edge, giving a latency of NIBBLES+1 cycles from acceptance to out_valid.
REQ-021 In DONE, out_valid=1; Y and cout are held stable until out_valid&&out_ready.
REQ-022 DONE->IDLE on out_ready; in_ready returns one cycle later, so back-to-back throughput is one result per NIBBLES+2 cycles.
REQ-023 {cout,Y} SHALL equal A+B+cin modulo 2^(W+1).
REQ-024 in_valid during RUN or DONE is ignored and not queued; operand changes after acceptance do not affect the result.
REQ-025 out_ready while not in DONE has no effect.

Reset
REQ-026 While rst_n=0 at a rising edge: state=IDLE, nibble index=0, carry=0, Y=0, cout=0, out_valid=0.
REQ-027 Reset asserted in RUN or DONE aborts the operation with no partial result presented; in_ready=1 on the first edge after rst_n returns high.

Configuration
REQ-028 Macro SEQ_ADDER_SUB_EN: when defined, the sub port exists; sub=1 at acceptance captures ~B and forces carry-in to 1, giving Y=A-B and cout=1 when A>=B (no borrow); cin is ignored when sub=1.
REQ-029 Without SEQ_ADDER_SUB_EN, the sub port and inversion logic are absent and behaviour is addition only.

Structure
REQ-030 Shared package seq_adder_pkg holds the FSM state enum, the nibble width constant (4), and the index width derived from the maximum NIBBLES.
REQ-031 One sub-module, cla4_slice (4-bit carry-lookahead adder: A, B, cin -> Y, cout), is instantiated exactly once.

Verification
REQ-032 Reset: rst_n=0 for 2 cycles -> in_ready=1, out_valid=0, Y=0, cout=0, busy=0.
REQ-033 Add: A=16'h1234, B=16'h4321, cin=0 -> out_valid after 5 cycles; Y=16'h5555, cout=0.
REQ-034 Carry ripple: A=16'hFFFF, B=16'h0000, cin=1 -> Y=16'h0000, cout=1.
REQ-035 Backpressure: out_ready=0 for 3 cycles in DONE -> Y is held and in_ready stays 0; in_valid pulsed during DONE is dropped.
REQ-036 Sub (macro defined): A=16'h0005, B=16'h0007, sub=1 -> Y=16'hFFFE, cout=0.
REQ-037 Abort: rst_n=0 in RUN at nibble 2 -> next cycle out_valid=0 and state IDLE; a new request A=1, B=1 yields Y=2.
